// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if: groups the pipeline-side request/response signals and the
// external asynchronous SRAM pins for sram_mem_ctrl.
//   slave  : the controller's view
//   master : the environment (pipeline plus SRAM device) view
interface sram_mem_ctrl_if #(
   parameter int unsigned SRAM_AW = 18
);
   logic               mem_read;
   logic               mem_write;
   logic [31:0]        alu_result;
   logic [31:0]        val_Rm;
   logic               ready;
   logic [31:0]        read_data;
   logic [SRAM_AW-1:0] sram_addr;
   logic [15:0]        sram_dq_out;
   logic [15:0]        sram_dq_in;
   logic               sram_dq_oe;
   logic               sram_we_n;
   logic               align_err;

   modport slave (
      input  mem_read, mem_write, alu_result, val_Rm, sram_dq_in,
      output ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, align_err
   );

   modport master (
      output mem_read, mem_write, alu_result, val_Rm, sram_dq_in,
      input  ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, align_err
   );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage data-memory sequencer. Each 32-bit load or store is
// split into two 16-bit phases (low halfword first) on an asynchronous SRAM,
// each phase held on the pins for WAIT_CYCLES cycles. ready is low while an
// access is in flight so the pipeline freezes.
// Optional macro SRAM_ALIGN_CHECK_EN: a misaligned request skips the SRAM,
// completes in one stall cycle and sets the sticky align_err flag.
module sram_mem_ctrl #(
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic           clk,
   input  logic           rst,
   sram_mem_ctrl_if.slave bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD_LO = 3'd1;
   localparam logic [2:0] RD_HI = 3'd2;
   localparam logic [2:0] WR_LO = 3'd3;
   localparam logic [2:0] WR_HI = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   logic [2:0]         state;
   logic [3:0]         cnt;
   logic [SRAM_AW-2:0] word_idx;
   logic [31:0]        data_q;
   logic [15:0]        lo_buf;
   logic [31:0]        read_data_q;
   logic               req;
   logic               last_cycle;
   logic               misaligned;
   logic [31:0]        phys;
   logic               unused_phys;

   assign req         = bus.mem_read | bus.mem_write;
   assign last_cycle  = (cnt == LAST_CNT);
   assign phys        = bus.alu_result - 32'(ADDR_BASE);
   // Bits above the SRAM range wrap away; the byte offset never reaches the pins.
   assign unused_phys = ^{phys[31:SRAM_AW+1], phys[1:0]};

`ifdef SRAM_ALIGN_CHECK_EN
   logic align_err_q;

   assign misaligned = (bus.alu_result[1:0] != 2'b00);

   // Sticky flag: set when a misaligned request is rejected, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         align_err_q <= 1'b0;
      end else if (state == IDLE && req && misaligned) begin
         align_err_q <= 1'b1;
      end
   end

   assign bus.align_err = align_err_q;
`else
   assign misaligned    = 1'b0;
   assign bus.align_err = 1'b0;
`endif

   // Access sequencer: latch the request in IDLE, walk LO then HI phase, finish in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: state lives in always_ff with non-blocking assignments only, so every
         // register samples pre-edge values regardless of statement order.
         state       <= IDLE;
         cnt         <= '0;
         word_idx    <= '0;
         data_q      <= '0;
         lo_buf      <= '0;
         read_data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  word_idx <= phys[SRAM_AW:2];
                  data_q   <= bus.val_Rm;
                  cnt      <= '0;
                  if (misaligned)         state <= DONE;
                  else if (bus.mem_read)  state <= RD_LO;
                  else                    state <= WR_LO;
               end
            end
            RD_LO, WR_LO: begin
               if (last_cycle) begin
                  cnt <= '0;
                  if (state == RD_LO) begin
                     lo_buf <= bus.sram_dq_in;
                     state  <= RD_HI;
                  end else begin
                     state  <= WR_HI;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RD_HI, WR_HI: begin
               if (last_cycle) begin
                  cnt <= '0;
                  // Both halves land together so a half-updated word is never visible.
                  if (state == RD_HI) read_data_q <= {bus.sram_dq_in, lo_buf};
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // SRAM pin drive decoded from the current phase; pins idle in every other state.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      bus.sram_addr   = '0;
      bus.sram_dq_out = '0;
      bus.sram_dq_oe  = 1'b0;
      bus.sram_we_n   = 1'b1;
      case (state)
         RD_LO: bus.sram_addr = {word_idx, 1'b0};
         RD_HI: bus.sram_addr = {word_idx, 1'b1};
         WR_LO: begin
            bus.sram_addr   = {word_idx, 1'b0};
            bus.sram_dq_out = data_q[15:0];
            bus.sram_dq_oe  = 1'b1;
            bus.sram_we_n   = 1'b0;
         end
         WR_HI: begin
            bus.sram_addr   = {word_idx, 1'b1};
            bus.sram_dq_out = data_q[31:16];
            bus.sram_dq_oe  = 1'b1;
            bus.sram_we_n   = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.ready     = ~req | (state == DONE);
   assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: self-checking bench for sram_mem_ctrl with a behavioural
// asynchronous SRAM. Expected pin activity and load data are queued when each
// access is issued and popped as the controller produces them.
module tb_sram_mem_ctrl;

   localparam int unsigned ADDR_BASE   = 1024;
   localparam int unsigned WAIT_CYCLES = 2;
   localparam int unsigned SRAM_AW     = 18;
   localparam int          MAX_CYCLES  = 40;

   typedef struct packed {
      logic [SRAM_AW-1:0] addr;
      logic               we_n;
      logic               oe;
      logic [15:0]        dq;
   } pins_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   sram_mem_ctrl_if #(.SRAM_AW(SRAM_AW)) bus ();

   sram_mem_ctrl #(
      .ADDR_BASE  (ADDR_BASE),
      .WAIT_CYCLES(WAIT_CYCLES),
      .SRAM_AW    (SRAM_AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM (1K halfwords): combinational read, write while we_n is low.
   logic [15:0] sram [0:1023];
   bit          sram_filled = 1'b0;

   assign bus.sram_dq_in = sram[bus.sram_addr[9:0]];

   always @(posedge clk) begin
      if (!sram_filled) begin
         for (int i = 0; i < 1024; i++) sram[i] <= 16'hA500 ^ 16'(i);
         sram_filled <= 1'b1;
      end else if (rst && !bus.sram_we_n) begin
         sram[bus.sram_addr[9:0]] <= bus.sram_dq_out;
      end
   end

   // Reference contents and scoreboard queues.
   logic [15:0] ref_mem [0:1023];
   pins_t       exp_pins[$];
   logic [31:0] exp_rd[$];
   logic [31:0] model_rd = 32'h0;

   // One access: queue expectations, drive, then compare pins cycle by cycle.
   task automatic run_access(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit drive, input bit chain, input logic [31:0] next_addr,
                             input bit misalign);
      logic [31:0]        phys;
      logic [SRAM_AW-1:0] lo_a;
      logic [SRAM_AW-1:0] hi_a;
      logic [9:0]         ilo;
      logic [9:0]         ihi;
      pins_t              p;
      int                 lat;
      int                 exp_lat;
      bit                 done;
      phys    = addr - 32'(ADDR_BASE);
      lo_a    = {phys[SRAM_AW:2], 1'b0};
      hi_a    = {phys[SRAM_AW:2], 1'b1};
      ilo     = lo_a[9:0];
      ihi     = hi_a[9:0];
      exp_lat = misalign ? 1 : 1 + 2 * int'(WAIT_CYCLES);

      p = '{addr: '0, we_n: 1'b1, oe: 1'b0, dq: 16'h0};
      exp_pins.push_back(p);
      if (!misalign) begin
         for (int i = 0; i < 2 * int'(WAIT_CYCLES); i++) begin
            p.addr = (i < int'(WAIT_CYCLES)) ? lo_a : hi_a;
            p.we_n = rd;
            p.oe   = !rd;
            p.dq   = rd ? 16'h0 : ((i < int'(WAIT_CYCLES)) ? wdata[15:0] : wdata[31:16]);
            exp_pins.push_back(p);
         end
         if (rd) begin
            model_rd = {ref_mem[ihi], ref_mem[ilo]};
         end else begin
            ref_mem[ilo] = wdata[15:0];
            ref_mem[ihi] = wdata[31:16];
         end
      end
      if (rd) exp_rd.push_back(model_rd);
      p = '{addr: '0, we_n: 1'b1, oe: 1'b0, dq: 16'h0};
      exp_pins.push_back(p);

      if (drive) begin
         bus.mem_read   = rd;
         bus.mem_write  = !rd;
         bus.alu_result = addr;
         bus.val_Rm     = wdata;
      end

      lat  = 0;
      done = 1'b0;
      for (int c = 0; c < MAX_CYCLES && !done; c++) begin
         @(negedge clk);
         if (exp_pins.size() != 0) begin
            p = exp_pins.pop_front();
            checks++;
            if ({bus.sram_addr, bus.sram_we_n, bus.sram_dq_oe} !== {p.addr, p.we_n, p.oe} ||
                (!p.we_n && bus.sram_dq_out !== p.dq)) begin
               errors++;
               $display("FAIL pins addr=%h cycle %0d: got addr=%h we_n=%b oe=%b dq=%h, want addr=%h we_n=%b oe=%b dq=%h",
                        addr, c, bus.sram_addr, bus.sram_we_n, bus.sram_dq_oe, bus.sram_dq_out,
                        p.addr, p.we_n, p.oe, p.dq);
            end
         end
         if (bus.ready === 1'b1) done = 1'b1;
         else                    lat++;
         if (chain && c == 1) begin
            bus.mem_write  = 1'b0;
            bus.mem_read   = 1'b1;
            bus.alu_result = next_addr;
            bus.val_Rm     = 32'h1234_5678;
         end
      end

      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout addr=%h: ready never rose within %0d cycles", addr, MAX_CYCLES);
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL latency addr=%h: ready low %0d cycles, want %0d", addr, lat, exp_lat);
      end
      if (rd && exp_rd.size() != 0) begin
         checks++;
         if (bus.read_data !== exp_rd[0]) begin
            errors++;
            $display("FAIL read_data addr=%h: got %h, want %h", addr, bus.read_data, exp_rd[0]);
         end
         void'(exp_rd.pop_front());
      end
      exp_pins.delete();

      @(posedge clk);
      #1;
      if (!chain) begin
         bus.mem_read  = 1'b0;
         bus.mem_write = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b, want 1", bus.ready);
      end
      checks++;
      if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
         errors++; $display("FAIL reset_pins: got we_n=%b oe=%b, want 1 0", bus.sram_we_n, bus.sram_dq_oe);
      end
      checks++;
      if (bus.read_data !== 32'h0) begin
         errors++; $display("FAIL reset_read_data: got %h, want 0", bus.read_data);
      end
      checks++;
      if (bus.sram_addr !== '0 || bus.align_err !== 1'b0) begin
         errors++; $display("FAIL reset_addr_align: got addr=%h align_err=%b, want 0 0", bus.sram_addr, bus.align_err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store();
      run_access(1'b0, 32'h408, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_load();
      run_access(1'b1, 32'h408, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.read_data !== 32'hDEAD_BEEF || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL load_hold idle %0d: got data=%h ready=%b, want deadbeef 1", i, bus.read_data, bus.ready);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 32'h408, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h500, 1'b0);
      run_access(1'b1, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid_access();
      logic [31:0]        phys;
      logic [SRAM_AW-1:0] hi_a;
      phys = 32'h408 - 32'(ADDR_BASE);
      hi_a = {phys[SRAM_AW:2], 1'b1};
      bus.mem_read   = 1'b1;
      bus.mem_write  = 1'b0;
      bus.alu_result = 32'h408;
      repeat (WAIT_CYCLES + 2) @(negedge clk);
      checks++;
      if (bus.sram_addr !== hi_a) begin
         errors++; $display("FAIL mid_reset_phase: got addr=%h, want %h", bus.sram_addr, hi_a);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.ready !== 1'b0 || bus.read_data !== 32'h0) begin
         errors++; $display("FAIL mid_reset_out: got ready=%b data=%h, want 0 0", bus.ready, bus.read_data);
      end
      checks++;
      if (bus.sram_addr !== '0 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_pins: got addr=%h we_n=%b oe=%b, want 0 1 0", bus.sram_addr, bus.sram_we_n, bus.sram_dq_oe);
      end
      bus.mem_read = 1'b0;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_ready_idle: got %b, want 1", bus.ready);
      end
      model_rd = 32'h0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_access(1'b1, 32'h408, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_align();
`ifdef SRAM_ALIGN_CHECK_EN
      run_access(1'b1, 32'h40A, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.align_err !== 1'b1) begin
            errors++; $display("FAIL align_sticky %0d: got %b, want 1", i, bus.align_err);
         end
      end
      @(posedge clk);
      #1;
      run_access(1'b1, 32'h408, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.align_err !== 1'b1) begin
         errors++; $display("FAIL align_after_aligned: got %b, want 1", bus.align_err);
      end
`else
      run_access(1'b1, 32'h40A, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.align_err !== 1'b0) begin
         errors++; $display("FAIL align_tied: got %b, want 0", bus.align_err);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 16'hA500 ^ 16'(i);
      rst            = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.alu_result = 32'h0;
      bus.val_Rm     = 32'h0;

      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_reset_mid_access();
      test_align();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
